// File: rtl/toggle_handshake_receiver.sv
// ---------------------------------------------------------------------------
// toggle_handshake_receiver
//
// Responder side of a two-phase (toggle) request/acknowledge link. A level
// change on the request line announces a new word on input_data. The toggle
// is synchronised into input_clock and the word is captured into a small
// first-word-fall-through buffer. The acknowledge line is flipped in the same
// edge as the capture. Buffered words are offered downstream on a
// valid/ready stream.
//
// Ports
//   input_clock            clock, all state updates on the rising edge
//   input_clear            synchronous active-high reset
//   input_req_toggle       request toggle from the sender (asynchronous)
//   input_data             word, held stable by the sender until acked
//   output_ack_toggle      acknowledge toggle, flips once per captured word
//   output_valid           buffer holds at least one word
//   input_ready            downstream takes the head word this cycle
//   output_data            head word (holds its last value when empty)
//   output_count           number of words currently buffered
//   output_protocol_error  sticky, sender toggled again before being acked
// ---------------------------------------------------------------------------
module toggle_handshake_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                                  input_clock,
    input  logic                                  input_clear,
    input  logic                                  input_req_toggle,
    input  logic [DATA_WIDTH-1:0]                 input_data,
    output logic                                  output_ack_toggle,
    output logic                                  output_valid,
    input  logic                                  input_ready,
    output logic [DATA_WIDTH-1:0]                 output_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       output_count,
    output logic                                  output_protocol_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_prev_q, req_prev_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       wr_q, wr_d;
    logic [PTR_W-1:0]       rd_q, rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic req_s;
    logic pending;
    logic full;
    logic push;
    logic pop;

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign pending = req_s ^ ack_q;
    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop     = (cnt_q != '0) && input_ready;
    // A full buffer that is popped in the same cycle still accepts the write.
    assign push    = pending && (!full || pop);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], input_req_toggle};
        req_prev_d = req_s;
        ack_d      = ack_q ^ push;

        // A change of req_s while the previous level is still unacked means
        // the sender toggled twice; req_s has returned to the ack level, so
        // the outstanding word is simply never pushed.
        err_d      = err_q | ((req_s ^ req_prev_q) & (req_prev_q ^ ack_q));

        // Depth is a power of two, so the pointers wrap naturally.
        wr_d       = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d       = pop  ? rd_q + PTR_W'(1) : rd_q;

        cnt_d      = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Registered head word. When the new head is the slot being written
        // in this same edge, take it straight from input_data so the word is
        // visible the cycle after capture. When the buffer empties, hold.
        data_d     = data_q;
        if (cnt_d != '0) begin
            if (push && (rd_d == wr_q)) begin
                data_d = input_data;
            end else begin
                data_d = mem_q[rd_d];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge input_clock) begin
        if (input_clear) begin
            sync_q     <= '0;
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
        end else begin
            sync_q     <= sync_d;
            req_prev_q <= req_prev_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge input_clock) begin
        if (input_clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_q] <= input_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all straight from registers
    // -----------------------------------------------------------------------
    assign output_ack_toggle     = ack_q;
    assign output_valid          = (cnt_q != '0);
    assign output_data           = data_q;
    assign output_count          = cnt_q;
    assign output_protocol_error = err_q;

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
module tb_toggle_handshake_receiver;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int FD = 2;
    localparam int CW = $clog2(FD + 1);

    logic          clk = 1'b0;
    logic          clr;
    logic          req;
    logic [DW-1:0] din;
    logic          ack;
    logic          valid;
    logic          ready;
    logic [DW-1:0] dout;
    logic [CW-1:0] cnt;
    logic          err;

    toggle_handshake_receiver #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .FIFO_DEPTH (FD)
    ) dut (
        .input_clock          (clk),
        .input_clear          (clr),
        .input_req_toggle     (req),
        .input_data           (din),
        .output_ack_toggle    (ack),
        .output_valid         (valid),
        .input_ready          (ready),
        .output_data          (dout),
        .output_count         (cnt),
        .output_protocol_error(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a word queue plus the request level as seen through
    // SS edges of latency (hist[i] = request sampled i+1 edges ago).
    logic [DW-1:0] mq[$];
    logic [DW-1:0] got[$];
    bit            hist[8];
    bit            m_ack;
    bit            m_err;
    logic [DW-1:0] m_last;
    int            maxcnt;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
        m_last = '0;
    endtask

    task automatic step();
        bit            dp;
        logic [DW-1:0] dw;
        bit            rs, rp, mpop, mpush;
        int            sz;
        dp = valid && ready;
        dw = dout;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            rs    = hist[SS-1];
            rp    = hist[SS];
            sz    = mq.size();
            mpop  = (sz > 0) && ready;
            mpush = (rs != m_ack) && ((sz < FD) || mpop);
            if ((rs != rp) && (rp != m_ack)) m_err = 1'b1;
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back(din);
                m_ack = ~m_ack;
            end
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = req;
            if (mq.size() > 0) m_last = mq[0];
            if (dp) got.push_back(dw);
        end
        #1;
        chk("ack",   ack,   m_ack);
        chk("valid", valid, mq.size() > 0);
        chk("count", cnt,   mq.size());
        chk("data",  dout,  m_last);
        chk("err",   err,   m_err);
        if (cnt > maxcnt) maxcnt = cnt;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack != req && n < 60) begin
            step();
            n++;
        end
        chk("ack_timeout", ack == req, 1);
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        wait_ack();
        din = d;
        req = ~req;
    endtask

    task automatic drain();
        int n = 0;
        ready = 1'b1;
        while (cnt != 0 && n < 60) begin
            step();
            n++;
        end
        step();
        ready = 1'b0;
        chk("drain_timeout", cnt, 0);
    endtask

    task automatic chk_got(input string tag, input logic [DW-1:0] exp[$]);
        chk({tag, "_n"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk(tag, got[i], exp[i]);
        end
    endtask

    logic ack_before;

    initial begin
        model_reset();
        clr = 1'b1; req = 1'b0; din = '0; ready = 1'b0;
        repeat (3) step();
        clr = 1'b0;
        chk("rst_ack", ack, 0);
        chk("rst_valid", valid, 0);
        chk("rst_count", cnt, 0);
        chk("rst_data", dout, 0);
        chk("rst_err", err, 0);
        step();

        // Single transfer, latency check
        din = 8'hA5; req = 1'b1;
        step(); chk("lat_k", ack, 0);
        step(); chk("lat_k1", ack, 0);
        step(); chk("lat_k2", ack, 1);
        chk("single_valid", valid, 1);
        chk("single_data", dout, 8'hA5);
        chk("single_count", cnt, 1);
        repeat (3) step();
        chk("single_ack_hold", ack, 1);
        ready = 1'b1; step(); ready = 1'b0;
        chk("single_popped", cnt, 0);
        chk("empty_hold", dout, 8'hA5);

        // Back-to-back into a full buffer
        got.delete();
        ack_before = ack;
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        repeat (6) step();
        chk("b2b_count", cnt, 2);
        chk("b2b_stall", ack != req, 1);
        chk("b2b_ack_twice", ack, ack_before);
        ready = 1'b1; step(); ready = 1'b0;
        chk("b2b_count_after", cnt, 2);
        chk("b2b_head", dout, 8'h22);
        chk("b2b_third_acked", ack == req, 1);
        drain();
        chk_got("b2b_order", '{8'h11, 8'h22, 8'h33});

        // Streaming with ready held high
        got.delete();
        maxcnt = 0;
        ready = 1'b1;
        for (int w = 1; w <= 8; w++) send_word(DW'(w));
        wait_ack();
        repeat (3) step();
        ready = 1'b0;
        chk_got("stream_order", '{8'h01, 8'h02, 8'h03, 8'h04,
                                  8'h05, 8'h06, 8'h07, 8'h08});
        chk("stream_maxcnt", maxcnt <= 1, 1);
        chk("stream_err", err, 0);

        // Double toggle while the buffer is full and the word is unacked
        got.delete();
        send_word(8'h41);
        send_word(8'h42);
        wait_ack();
        ack_before = ack;
        din = 8'h5A; req = ~req;
        step();
        req = ~req;
        repeat (6) step();
        chk("viol_err", err, 1);
        chk("viol_ack", ack, ack_before);
        chk("viol_count", cnt, 2);
        drain();
        chk_got("viol_words", '{8'h41, 8'h42});
        repeat (4) step();
        chk("viol_sticky", err, 1);

        // Reset with a full buffer and one pending word
        send_word(8'h61);
        send_word(8'h62);
        send_word(8'h63);
        repeat (3) step();
        chk("mid_full", cnt, 2);
        clr = 1'b1; req = 1'b0; din = '0;
        step();
        clr = 1'b0;
        chk("mid_valid", valid, 0);
        chk("mid_count", cnt, 0);
        chk("mid_ack", ack, 0);
        chk("mid_err", err, 0);
        send_word(8'hC3);
        wait_ack();
        chk("mid_fresh_data", dout, 8'hC3);
        chk("mid_fresh_count", cnt, 1);
        got.delete();
        drain();
        chk_got("mid_fresh_pop", '{8'hC3});

        // Pointer wrap through the two-entry buffer
        got.delete();
        send_word(8'h10);
        send_word(8'h11);
        wait_ack();
        ready = 1'b1;
        send_word(8'h12);
        send_word(8'h13);
        send_word(8'h14);
        wait_ack();
        drain();
        chk_got("wrap_order", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
        chk("wrap_count", cnt, 0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            ready = 1'($urandom_range(0, 1));
            if (ack == req && $urandom_range(0, 3) == 0) begin
                din = DW'($urandom);
                req = ~req;
            end
            step();
        end
        wait_ack();
        drain();
        chk("rand_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_handshake_receiver.md
Name: toggle_handshake_receiver

Overview:
- Receiving end of the two-phase (toggle) request/acknowledge link. The sender flips a T flip-flop request line for each word; this block is the responder on that link.
- Synchronises the request toggle into the local clock and captures the held data word into a small first-word-fall-through buffer.
- Toggles the acknowledge line once each word is captured, and presents buffered words on a valid/ready stream to downstream logic.

Parameters:
DATA_WIDTH, 8, width of transferred word
SYNC_STAGES, 2, flops in request synchroniser chain (legal range 2..4)
FIFO_DEPTH, 2, buffer entries (power of two, legal range 2..8)

Ports:
input_clock  in  1  single clock; all state updates on rising edge
input_clear  in  1  reset: synchronous, active-high
input_req_toggle  in  1  request from sender; each level change = one new word
input_data  in  DATA_WIDTH  word; sender holds it stable from its toggle until it sees the matching ack toggle
output_ack_toggle  out  1  acknowledge; flips once per captured word
output_valid  out  1  buffer non-empty
input_ready  in  1  downstream accepts head word this cycle
output_data  out  DATA_WIDTH  head word of buffer
output_count  out  clog2(FIFO_DEPTH+1)  words currently buffered
output_protocol_error  out  1  sticky; sender toggled again before previous word was acknowledged

Behaviour:
- Reset (input_clear=1 at an edge): clears synchroniser flops, req_prev, ack, pointers, count, error flag and storage to 0.
  - After reset: output_ack_toggle=0, output_valid=0, output_count=0, output_data=0, output_protocol_error=0.
  - Reset overrides every other event in the same cycle.
- Synchroniser: input_req_toggle passes through SYNC_STAGES flops; req_s = last stage. req_prev = req_s delayed one cycle.
- input_data is sampled directly, with no synchroniser; it is legal because it is stable before the toggle propagates.
- pending = (req_s != output_ack_toggle).
- push = pending AND (count < FIFO_DEPTH OR pop). A full buffer popped in the same cycle accepts the write.
- On push:
  - input_data is written at the tail.
  - output_ack_toggle inverts at the same edge.
  - pending therefore clears the following cycle.
- pop = output_valid AND input_ready; head advances at the edge.
- Count update:
  - push without pop: +1.
  - pop without push: -1.
  - both: unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - A toggle first sampled at edge k is written, and ack is toggled, at edge k+SYNC_STAGES.
  - output_valid is high after that edge, and output_data shows the word in that same cycle (fall-through).
- Full with pending: ack is withheld, so the sender stalls. The write happens at the first edge where a slot frees or a pop occurs.
- Empty: output_valid=0. input_ready is ignored and output_data holds its last value.
- Protocol error:
  - Condition: set at an edge where req_s != req_prev AND req_prev != output_ack_toggle, i.e. a second toggle arrives while a word is outstanding.
  - The outstanding word is lost: req_s returns to the ack value, so no push occurs.
  - The flag stays 1 until input_clear.
- Reset mid-operation:
  - Buffered and pending words are discarded and ack returns to 0.
  - If the sender's request level is 1 after reset, it is seen as a new transfer after SYNC_STAGES edges. The sender must therefore be reset in the same cycle.
- No combinational path from input_req_toggle to any output. output_valid, output_data and output_count derive from registers only.

Test Plan:
- Reset, then a single transfer: req 0->1 with data=0xA5, ready=0 (SYNC_STAGES=2) -> ack 0->1 two edges after first sampling; valid=1, data=0xA5, count=1; ack stays 1 thereafter.
- Back-to-back words 0x11, 0x22, 0x33, ready=0, FIFO_DEPTH=2 -> ack toggles twice and count=2. Third toggle stays unacked until ready=1 for one cycle; then 0x11 pops, 0x33 is written the same edge, ack toggles, count stays 2.
- Streaming: ready=1 constantly, sender toggles again immediately after each ack with words 0x01..0x08 -> all 8 words appear in order, count never exceeds 1, error=0.
- Violation: toggle with 0x5A, then toggle again one cycle later before ack -> output_protocol_error=1 and stays 1; no push for 0x5A; ack unchanged.
- Mid-operation reset: count=2 and one word pending, assert input_clear one cycle with sender reset too -> the next cycle shows valid=0, count=0, ack=0, error=0. A subsequent fresh transfer of 0xC3 completes normally.
- Pointer wrap: push and pop 5 words (0x10..0x14) through FIFO_DEPTH=2 -> order preserved across wrap; output_count returns to 0.
